// File: rtl/fft_in_framer.sv
// fft_in_framer
//   Ingress framer for the 64-point FFT pipeline. Samples from a valid/ready
//   source are collected into a 2 x N ping-pong buffer. Each complete frame is
//   replayed to the core as a start pulse plus N back-to-back samples. Start
//   pulses are kept at least FRAME_GAP cycles apart so that consecutive frames
//   never overlap the core's busy window.
//
//   Optional feature macro: FRAMER_LAST_CHK_EN
//     When defined, s_last is checked against the sample index. An early s_last
//     drops the partial frame. A missing s_last on sample N-1 still commits the
//     frame. Both cases pulse frame_err.
//     When undefined, s_last is ignored and frame_err is tied to 0.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   s_valid/s_ready      source handshake; s_re/s_im sample, s_last frame marker
//   start                one-cycle pulse, coincides with sample 0 on d_*
//   d_valid/d_re/d_im    frame samples to PE0 (registered)
//   frame_err            one-cycle framing error pulse
//   busy                 frame buffered or streaming, or start gap still running
module fft_in_framer #(
    parameter int DW        = 16,
    parameter int N         = 64,
    parameter int FRAME_GAP = 185
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_re,
    input  logic [DW-1:0] s_im,
    input  logic          s_last,
    output logic          start,
    output logic          d_valid,
    output logic [DW-1:0] d_re,
    output logic [DW-1:0] d_im,
    output logic          frame_err,
    output logic          busy
);

    localparam int IW = $clog2(N);
    localparam int GW = $clog2(FRAME_GAP + 1);

    typedef enum logic {IDLE, STREAM} state_t;

    // Sample storage: address is {bank, index}. Deliberately not reset.
    logic [2*DW-1:0] mem [0:2*N-1];

    logic [1:0]    full;
    logic          wr_bank, rd_bank;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [GW-1:0] gap_cnt;
    logic          gap_expired;
    state_t        state, state_nxt;

    logic accept, wr_end, wr_drop;
    logic rd_fire, rd_done, rd_first;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign s_ready = ~full[wr_bank];
    assign accept  = s_valid & s_ready;
    assign wr_end  = (wr_idx == IW'(N - 1));

`ifdef FRAMER_LAST_CHK_EN
    logic wr_err;
    // Early s_last throws away the partial frame; a missing s_last on the
    // final sample is only flagged, and the frame is still committed.
    assign wr_drop = accept & s_last & ~wr_end;
    assign wr_err  = wr_drop | (accept & wr_end & ~s_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= wr_err;
    end
`else
    logic last_unused;
    assign last_unused = s_last;
    assign wr_drop     = 1'b0;
    assign frame_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (accept) mem[{wr_bank, wr_idx}] <= {s_re, s_im};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (accept) begin
            if (wr_drop) begin
                wr_idx <= '0;
            end else begin
                wr_idx <= wr_idx + 1'b1;   // wraps to 0 after N-1
                if (wr_end) wr_bank <= ~wr_bank;
            end
        end
    end

    // The read side only clears the bank it streams and the write side only
    // sets a bank that is empty, so the two updates never hit the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (rd_done)                      full[rd_bank] <= 1'b0;
            if (accept && wr_end && !wr_drop) full[wr_bank] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // rd_fire: an output register load happens on this edge. The first load
    // is issued from IDLE so sample 0 appears on the edge after the frame
    // became full.
    always_comb begin
        state_nxt = state;
        rd_fire   = 1'b0;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank] && gap_expired) begin
                    rd_fire   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM:  rd_fire   = 1'b1;
            default: state_nxt = IDLE;
        endcase
        if (rd_fire && rd_idx == IW'(N - 1)) begin
            rd_done   = 1'b1;
            state_nxt = IDLE;
        end
    end

    assign rd_first = rd_fire & (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            start   <= 1'b0;
            d_valid <= 1'b0;
            d_re    <= '0;
            d_im    <= '0;
        end else begin
            start   <= rd_first;
            d_valid <= rd_fire;
            if (rd_fire) begin
                {d_re, d_im} <= mem[{rd_bank, rd_idx}];
                rd_idx       <= rd_idx + 1'b1;
            end
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    // Gap counter: loaded with FRAME_GAP-1 on the start edge, so it reads
    // zero (expired) in time for a start exactly FRAME_GAP edges later.
    assign gap_expired = (gap_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            gap_cnt <= '0;
        else if (rd_first)     gap_cnt <= GW'(FRAME_GAP - 1);
        else if (!gap_expired) gap_cnt <= gap_cnt - 1'b1;
    end

    assign busy = (|full) | (state != IDLE) | ~gap_expired;

endmodule

// File: tb/tb_fft_in_framer.sv
module tb_fft_in_framer;
    localparam int DW = 16;
    localparam int N  = 64;
    localparam int G  = 185;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          s_valid = 1'b0, s_last = 1'b0;
    logic [DW-1:0] s_re = '0, s_im = '0;
    logic          s_ready, start, d_valid, frame_err, busy;
    logic [DW-1:0] d_re, d_im;

    fft_in_framer #(.DW(DW), .N(N), .FRAME_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .s_last(s_last), .start(start),
        .d_valid(d_valid), .d_re(d_re), .d_im(d_im),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;   // number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    // Reference model: accepted samples in order, edges at which frames
    // become full, expected start edges, expected frame_err edges.
    logic [2*DW-1:0] samp_q[$];
    int fe[$], se[$], err_q[$], act_st[$];
    int wcnt = 0, mon_k = 0, frames_exp = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Called at the negedge before the accepting edge.
    task automatic model_accept(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        int t;
        int s;
        logic [2*DW-1:0] dummy;
        t = cyc + 1;
        samp_q.push_back({re, im});
        wcnt++;
`ifdef FRAMER_LAST_CHK_EN
        if (last && wcnt < N) begin
            err_q.push_back(t);
            repeat (wcnt) dummy = samp_q.pop_back();
            wcnt = 0;
            return;
        end
        if (!last && wcnt == N) err_q.push_back(t);
`else
        dummy = {re, im} ^ {2*DW{last}};
`endif
        if (wcnt == N) begin
            fe.push_back(t);
            if (se.size() == 0) s = t + 1;
            else s = (t + 1 > se[$] + G) ? t + 1 : se[$] + G;
            se.push_back(s);
            frames_exp++;
            wcnt = 0;
        end
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit thr, input logic last);
        int w = 0;
        if (thr) begin s_valid = 1'b0; @(negedge clk); end
        s_valid = 1'b1; s_re = re; s_im = im; s_last = last;
        while (!s_ready && w < 3000) begin @(negedge clk); w++; end
        if (!s_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout cycle=%0d got=s_ready_low expected=s_ready_high", cyc);
            s_valid = 1'b0;
            return;
        end
        model_accept(re, im, last);
        @(negedge clk);
    endtask

    // mode 0: ramp re=i im=-i, mode 1: random
    task automatic send_frame(input int mode, input bit thr, input int last_at);
        for (int i = 0; i < N; i++) begin
            if (mode == 0) send(DW'(i), DW'(-i), thr, i == last_at);
            else send(DW'($urandom), DW'($urandom), thr, i == last_at);
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (w < 3000 && !(mon_k == se.size() && wcnt == 0 &&
               (se.size() == 0 || cyc >= se[$] + G + 2))) begin
            @(negedge clk); w++;
        end
        chk("idle_reached", (w < 3000), 1'b1);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        samp_q.delete(); fe.delete(); se.delete(); err_q.delete();
        wcnt = 0; mon_k = 0; s_valid = 1'b0; s_last = 1'b0;
        #1;
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        bit ev, es, eerr, started;
        int nfull, ndrain, ls;
        logic [2*DW-1:0] e;
        if (mon_en && rst_n) begin
            ev = 1'b0; es = 1'b0; eerr = 1'b0; started = 1'b0;
            nfull = 0; ndrain = 0; ls = 0;
            if (mon_k < se.size() && cyc >= se[mon_k] && cyc < se[mon_k] + N) begin
                ev = 1'b1;
                es = (cyc == se[mon_k]);
            end
            chk("d_valid", d_valid, ev);
            chk("start", start, es);
            if (start) act_st.push_back(cyc);
            if (d_valid) begin
                if (samp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d_data cycle=%0d got=%0h expected=no_output", cyc, {d_re, d_im});
                end else begin
                    e = samp_q.pop_front();
                    chk("d_data", {d_re, d_im}, e);
                end
            end
            if (ev && cyc == se[mon_k] + N - 1) mon_k++;
            foreach (fe[i]) if (fe[i] <= cyc) nfull++;
            foreach (se[i]) begin
                if (se[i] + N - 1 <= cyc) ndrain++;
                if (se[i] <= cyc) begin started = 1'b1; ls = se[i]; end
            end
            chk("s_ready", s_ready, (nfull - ndrain) < 2);
            if ((nfull - ndrain) > 0 || (started && cyc <= ls + G - 2))
                chk("busy_high", busy, 1'b1);
            else if (!started || cyc >= ls + G)
                chk("busy_low", busy, 1'b0);
            foreach (err_q[i]) if (err_q[i] == cyc) eerr = 1'b1;
            chk("frame_err", frame_err, eerr);
        end
    end

    initial begin
        int b, w;
        #1;
        chk("reset_s_ready", s_ready, 1'b1);
        chk("reset_start", start, 1'b0);
        chk("reset_d_valid", d_valid, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_data", {d_re, d_im}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single ramp frame
        send_frame(0, 1'b0, N - 1);
        wait_idle();

        // Three frames back-to-back, s_valid held high
        b = act_st.size();
        for (int f = 0; f < 3; f++) send_frame(1, 1'b0, N - 1);
        wait_idle();
        chk("b2b_starts", act_st.size() - b, 3);
        if (act_st.size() - b == 3) begin
            chk("b2b_spacing01", act_st[b + 1] - act_st[b], G);
            chk("b2b_spacing12", act_st[b + 2] - act_st[b + 1], G);
        end

        // Throttled source: valid every other cycle
        send_frame(1, 1'b1, N - 1);
        wait_idle();

        // Reset at output sample 20
        send_frame(1, 1'b0, N - 1);
        w = 0;
        while (cyc != se[$] + 20 && w < 1000) begin @(negedge clk); w++; end
        chk("reach_sample20", w < 1000, 1'b1);
        do_reset();
        repeat (250) @(negedge clk);
        send_frame(0, 1'b0, N - 1);
        wait_idle();

`ifdef FRAMER_LAST_CHK_EN
        // Early s_last on sample 30 then a clean frame
        b = act_st.size();
        for (int i = 0; i < 31; i++) send(DW'($urandom), DW'($urandom), 1'b0, i == 30);
        send_frame(1, 1'b0, N - 1);
        wait_idle();
        chk("early_last_starts", act_st.size() - b, 1);
        // Missing s_last: frame still streamed
        send_frame(1, 1'b0, N);
        wait_idle();
        chk("missing_last_starts", act_st.size() - b, 2);
`endif

        chk("frames_out", act_st.size(), frames_exp);
        chk("sample_queue_empty", samp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
